// File: rtl/simd_batch_unit.sv
// simd_batch_unit: batch blend datapath for the SIMD batch controller.
//
// Captures LANES pixel pairs (a, b) plus one shared weight w on load_regs. On
// run_simd every lane is blended through a single shared 2-stage pipeline, one
// lane per cycle:
//   res = (a*(256-w) + b*w + 128) >> 8
// When the batch completes, simd_valid pulses for one cycle. The result is then
// held until the next run.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load_regs   capture a_in/b_in/w_in
//   run_simd    start processing the captured batch (1-cycle strobe)
//   a_in, b_in  LANES*DW packed lanes, lane i at [i*DW +: DW]
//   w_in        shared blend weight
//   result      registered blended lanes
//   simd_valid  1-cycle pulse when the full batch is in result
//   busy        high while lanes are issuing/draining
//   err         registered 1-cycle pulse after a protocol violation
module simd_batch_unit #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_regs,
    input  logic                  run_simd,
    input  logic [LANES*DW-1:0]   a_in,
    input  logic [LANES*DW-1:0]   b_in,
    input  logic [DW-1:0]         w_in,
    output logic [LANES*DW-1:0]   result,
    output logic                  simd_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned PW = 2 * DW + 1;  // product / sum width

    typedef enum logic [1:0] {StIdle, StLoaded, StBusy, StDone} state_e;

    state_e                state_q, state_d;
    logic [LANES*DW-1:0]   a_q, b_q;
    logic [DW-1:0]         w_q;
    logic [CW-1:0]         cnt_q;
    logic                  issue_done_q;
    logic                  s1_valid_q;
    logic [CW-1:0]         s1_lane_q;
    logic [PW-1:0]         pa_q, pb_q;
    logic [LANES*DW-1:0]   result_q;
    logic                  err_q, err_d;

    logic                  load_en;
    logic                  start;
    logic                  issue;
    logic [DW-1:0]         a_lane, b_lane;
    logic [DW:0]           w_inv;
    logic [PW-1:0]         pa_d, pb_d;
    logic [PW-1:0]         sum;
    logic [DW-1:0]         blended;

    // Control FSM: next state, strobes and protocol-violation detection.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        load_en = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_regs) begin
                    load_en = 1'b1;
                    state_d = StLoaded;
                end
                // run with nothing loaded, or run alongside a load: run dropped
                if (run_simd) err_d = 1'b1;
            end
            StLoaded: begin
                if (load_regs) begin
                    load_en = 1'b1;
                    if (run_simd) err_d = 1'b1;
                end else if (run_simd) begin
                    start   = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (load_regs || run_simd) err_d = 1'b1;
                // last lane is in stage 2 this cycle
                if (issue_done_q && s1_valid_q) state_d = StDone;
            end
            StDone: begin
                if (load_regs || run_simd) err_d = 1'b1;
                state_d = StLoaded;
            end
            default: state_d = StIdle;
        endcase
    end

    assign issue = (state_q == StBusy) && !issue_done_q;

    // Select the operands of the lane currently being issued.
    always_comb begin
        a_lane = '0;
        b_lane = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (cnt_q == CW'(i)) begin
                a_lane = a_q[i*DW +: DW];
                b_lane = b_q[i*DW +: DW];
            end
        end
    end

    assign w_inv   = (DW+1)'(1 << DW) - {1'b0, w_q};
    assign pa_d    = PW'(a_lane) * PW'(w_inv);
    assign pb_d    = PW'(b_lane) * PW'(w_q);
    // Sum never exceeds 65408, so the shifted value always fits in DW bits.
    assign sum     = pa_q + pb_q + PW'(1 << (DW - 1));
    assign blended = DW'(sum >> DW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            w_q          <= '0;
            cnt_q        <= '0;
            issue_done_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_lane_q    <= '0;
            pa_q         <= '0;
            pb_q         <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;

            if (load_en) begin
                a_q <= a_in;
                b_q <= b_in;
                w_q <= w_in;
            end

            // Lane counter parks at LANES-1; issue_done stops further issue.
            if (start) begin
                cnt_q        <= '0;
                issue_done_q <= 1'b0;
            end else if (issue) begin
                if (cnt_q == CW'(LANES - 1)) issue_done_q <= 1'b1;
                else                         cnt_q        <= cnt_q + CW'(1);
            end

            // Stage 1: register both products.
            s1_valid_q <= issue;
            if (issue) begin
                s1_lane_q <= cnt_q;
                pa_q      <= pa_d;
                pb_q      <= pb_d;
            end

            // Stage 2: round and write back the lane.
            for (int i = 0; i < int'(LANES); i++) begin
                if (s1_valid_q && (s1_lane_q == CW'(i))) begin
                    result_q[i*DW +: DW] <= blended;
                end
            end
        end
    end

    assign result     = result_q;
    assign simd_valid = (state_q == StDone);
    assign busy       = (state_q == StBusy);
    assign err        = err_q;

endmodule

// File: tb/tb_simd_batch_unit.sv
// Testbench for simd_batch_unit (LANES=4, DW=8): table-driven batches with a
// scoreboard queue of expected results, plus hand-written protocol sequences.
module tb_simd_batch_unit;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                load_regs;
    logic                run_simd;
    logic [LANES*DW-1:0] a_in, b_in;
    logic [DW-1:0]       w_in;
    logic [LANES*DW-1:0] result;
    logic                simd_valid;
    logic                busy;
    logic                err;

    simd_batch_unit #(.LANES(LANES), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_regs  (load_regs),
        .run_simd   (run_simd),
        .a_in       (a_in),
        .b_in       (b_in),
        .w_in       (w_in),
        .result     (result),
        .simd_valid (simd_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  w;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference blend, written directly from the arithmetic definition.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [7:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            int ai, bi, wi, v;
            ai = int'(a[i*8 +: 8]);
            bi = int'(b[i*8 +: 8]);
            wi = int'(w);
            v  = (ai * (256 - wi) + bi * wi + 128) / 256;
            r[i*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [7:0] w);
        a_in      = a;
        b_in      = b;
        w_in      = w;
        load_regs = 1'b1;
        tick();
        load_regs = 1'b0;
    endtask

    // Optionally reload, pulse run, optionally inject a load in busy cycle 2,
    // then wait (bounded) for simd_valid and check latency and result.
    task automatic run_batch(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [7:0] w, input logic [31:0] exp,
                             input bit reload, input bit inject);
        int          got;
        bit          done;
        logic [31:0] want;
        if (reload) load(a, b, w);
        sb_q.push_back(exp);
        run_simd = 1'b1;
        tick();
        run_simd = 1'b0;
        got  = 0;
        done = 1'b0;
        for (int k = 1; k <= int'(LANES) + 8; k++) begin
            if (!done) begin
                if (simd_valid) begin
                    got  = k;
                    done = 1'b1;
                end else begin
                    check({name, "_busy"}, busy, 1'b1);
                    if (inject && k == 3) check({name, "_err_inject"}, err, 1'b1);
                    if (inject && k == 2) begin
                        a_in      = ~a;
                        b_in      = ~b;
                        w_in      = ~w;
                        load_regs = 1'b1;
                    end
                    tick();
                    load_regs = 1'b0;
                end
            end
        end
        check({name, "_latency"}, got, LANES + 2);
        want = sb_q.pop_front();
        if (done) begin
            check({name, "_result"}, result, want);
            tick();
            check({name, "_valid_pulse"}, simd_valid, 1'b0);
            check({name, "_hold"}, result, want);
        end
    endtask

    initial begin
        int seen;
        vecs[0] = '{{8'd40, 8'd30, 8'd20, 8'd10}, 32'hFFFF_FFFF, 8'd0,
                    {8'd40, 8'd30, 8'd20, 8'd10}};
        vecs[1] = '{32'h0A0A_0A0A, 32'h0B0B_0B0B, 8'd128, 32'h0B0B_0B0B};
        vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 8'd255, 32'hFEFE_FEFE};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd255, 32'hFFFF_FFFF};
        vecs[4] = '{{8'd50, 8'd200, 8'd0, 8'd100}, {8'd200, 8'd50, 8'd100, 8'd0}, 8'd64,
                    {8'd88, 8'd163, 8'd25, 8'd75}};

        rst       = 1'b1;
        load_regs = 1'b0;
        run_simd  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        w_in      = '0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset: everything quiet.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_result", result, 0);
            check("idle_valid", simd_valid, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_err", err, 1'b0);
        end

        // run_simd with nothing loaded.
        run_simd = 1'b1;
        tick();
        run_simd = 1'b0;
        check("run_idle_err", err, 1'b1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (simd_valid || busy) seen++;
            if (i == 0) check("run_idle_err_pulse", err, 1'b0);
        end
        check("run_idle_no_valid", seen, 0);

        // Table-driven batches.
        for (int v = 0; v < 5; v++) begin
            run_batch($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].w, vecs[v].exp,
                      1'b1, 1'b0);
        end

        // load_regs and run_simd together: load taken, run dropped.
        a_in      = {8'd8, 8'd7, 8'd6, 8'd5};
        b_in      = {8'd250, 8'd251, 8'd252, 8'd253};
        w_in      = 8'd3;
        load_regs = 1'b1;
        run_simd  = 1'b1;
        tick();
        load_regs = 1'b0;
        run_simd  = 1'b0;
        check("load_run_err", err, 1'b1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy || simd_valid) seen++;
            tick();
        end
        check("load_run_no_busy", seen, 0);
        run_batch("load_run_later", '0, '0, '0,
                  model({8'd8, 8'd7, 8'd6, 8'd5}, {8'd250, 8'd251, 8'd252, 8'd253}, 8'd3),
                  1'b0, 1'b0);

        // New load during busy cycle 2 must not disturb the batch.
        run_batch("inject", vecs[4].a, vecs[4].b, vecs[4].w, vecs[4].exp, 1'b1, 1'b1);

        // Rerun without reload gives the same batch.
        run_batch("rerun", '0, '0, '0, vecs[4].exp, 1'b0, 1'b0);

        // Reset in busy cycle 2 abandons the batch.
        load(vecs[1].a, vecs[1].b, vecs[1].w);
        run_simd = 1'b1;
        tick();
        run_simd = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_result", result, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (simd_valid) seen++;
        end
        check("rst_no_valid", seen, 0);

        // Fresh batch after reset completes normally.
        run_batch("fresh", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd90, 8'd80, 8'd70, 8'd60}, 8'd200,
                  model({8'd4, 8'd3, 8'd2, 8'd1}, {8'd90, 8'd80, 8'd70, 8'd60}, 8'd200),
                  1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
